// File: rtl/flash_cfg_pkg.sv
// flash_cfg_pkg
//   Shared types and constants for the flash configuration image loader.
//   - state_e          : parser state encoding
//   - MAGIC_DEFAULT    : image signature (big-endian, first two bytes)
//   - HDR_LEN          : header bytes (magic + record count)
//   - *_DEFAULT        : default record geometry and record-count limit
//   Optional feature macro used by consumers: CFG_CHECKSUM_EN
package flash_cfg_pkg;

  typedef enum logic [3:0] {
    ST_MAGIC0 = 4'd0,
    ST_MAGIC1 = 4'd1,
    ST_CNT0   = 4'd2,
    ST_CNT1   = 4'd3,
    ST_ADDR   = 4'd4,
    ST_DATA   = 4'd5,
    ST_WRITE  = 4'd6,
    ST_CSUM   = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERROR  = 4'd9
  } state_e;

  localparam logic [15:0] MAGIC_DEFAULT       = 16'hC0F1;
  localparam int          HDR_LEN             = 4;
  localparam int          MAX_RECORDS_DEFAULT = 256;
  localparam int          ADDR_W_DEFAULT      = 8;
  localparam int          DATA_BYTES_DEFAULT  = 4;

endpackage

// File: rtl/flash_cfg_loader.sv
// flash_cfg_loader
//   Parses a boot configuration image streamed from the SPI flash reader and
//   replays its address/data records onto the config register write port.
//   Once the image is applied (done) or rejected (error) the byte stream is
//   stalled permanently until reset.
//
//   Ports
//     clk        : system clock
//     rst        : asynchronous reset, active low
//     s_tdata/s_tvalid/s_tready : 8-bit AXI-Stream byte input
//     cfg_valid/cfg_ready       : register write handshake
//     cfg_addr   : write address (one image byte, zero-extended)
//     cfg_data   : write data (DATA_BYTES image bytes, MSB first)
//     done/error : sticky completion / rejection flags
//     rec_count  : records written since reset
//
//   Optional feature: define CFG_CHECKSUM_EN to require a trailing checksum
//   byte making the mod-256 sum of every post-magic byte equal zero.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_MAGIC0 | expect MAGIC[15:8]
//   ST_MAGIC1 | expect MAGIC[7:0]
//   ST_CNT0   | capture record count high byte
//   ST_CNT1   | capture record count low byte, range-check it
//   ST_ADDR   | capture record address byte
//   ST_DATA   | shift in record data bytes
//   ST_WRITE  | present record on cfg port until accepted
//   ST_CSUM   | check trailing checksum byte (checksum build only)
//   ST_DONE   | image applied, terminal
//   ST_ERROR  | image rejected, terminal
module flash_cfg_loader
  import flash_cfg_pkg::*;
#(
  parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
  parameter int          MAX_RECORDS = MAX_RECORDS_DEFAULT,
  parameter int          ADDR_W      = ADDR_W_DEFAULT,
  parameter int          DATA_BYTES  = DATA_BYTES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    cfg_valid,
  input  logic                    cfg_ready,
  output logic [ADDR_W-1:0]       cfg_addr,
  output logic [8*DATA_BYTES-1:0] cfg_data,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             rec_count
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        rec_count_q, rec_count_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // Holds s_tready low for the first cycle out of reset so every output
  // reads zero while rst is asserted.
  logic               run_q, run_d;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] cnt_full;
  logic [15:0] rec_next;

  assign accept   = s_tvalid && s_tready;
  assign cnt_full = {cnt_q[15:8], s_tdata};
  assign rec_next = rec_count_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rec_count_d = rec_count_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    run_d       = 1'b1;
`ifdef CFG_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_MAGIC0: if (accept) begin
        state_d = (s_tdata == MAGIC[15:8]) ? ST_MAGIC1 : ST_ERROR;
      end
      ST_MAGIC1: if (accept) begin
        state_d = (s_tdata == MAGIC[7:0]) ? ST_CNT0 : ST_ERROR;
      end
      ST_CNT0: if (accept) begin
        cnt_d   = {s_tdata, 8'h00};
        state_d = ST_CNT1;
`ifdef CFG_CHECKSUM_EN
        csum_d  = csum_q + s_tdata;
`endif
      end
      ST_CNT1: if (accept) begin
        cnt_d = cnt_full;
`ifdef CFG_CHECKSUM_EN
        csum_d = csum_q + s_tdata;
`endif
        if (cnt_full == 16'd0) begin
`ifdef CFG_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else if (cnt_full > 16'(MAX_RECORDS)) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: if (accept) begin
        addr_d  = ADDR_W'(s_tdata);
        idx_d   = '0;
        state_d = ST_DATA;
`ifdef CFG_CHECKSUM_EN
        csum_d  = csum_q + s_tdata;
`endif
      end
      ST_DATA: if (accept) begin
        data_d = (data_q << 8) | DATA_W'(s_tdata);
`ifdef CFG_CHECKSUM_EN
        csum_d = csum_q + s_tdata;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = ST_WRITE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_WRITE: if (cfg_ready) begin
        rec_count_d = rec_next;
        if (rec_next == cnt_q) begin
`ifdef CFG_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_ADDR;
        end
      end
`ifdef CFG_CHECKSUM_EN
      ST_CSUM: if (accept) begin
        state_d = (8'(csum_q + s_tdata) == 8'h00) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_MAGIC0;
      cnt_q       <= '0;
      rec_count_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      run_q       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rec_count_q <= rec_count_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
`ifdef CFG_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    s_tready = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_MAGIC0, ST_MAGIC1, ST_CNT0, ST_CNT1, ST_ADDR, ST_DATA, ST_CSUM: s_tready = 1'b1;
        default: s_tready = 1'b0;
      endcase
    end
  end

  assign cfg_valid = (state_q == ST_WRITE);
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_flash_cfg_loader.sv
// tb_flash_cfg_loader
//   Builds configuration images from record lists, streams them into the
//   loader with random gaps and write backpressure, and checks every write,
//   the record counter and the final done/error outcome against expectations
//   derived from the image format. Define CFG_CHECKSUM_EN for the checksum build.
module tb_flash_cfg_loader;
  import flash_cfg_pkg::*;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        cfg_valid;
  logic        cfg_ready = 1'b1;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        done, error;
  logic [15:0] rec_count;

  flash_cfg_loader dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .done(done), .error(error), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- model state ----------------
  logic [7:0] img[$];
  rec_t       exp_q[$];
  rec_t       log_q[$];
  int         writes_seen = 0;
  int         exp_recs = 0;
  bit         exp_done = 0, exp_error = 0;
  bit         chk_en = 0;
  bit         ready_rand = 0, gap_en = 0;
  bit         stall_arm = 0;
  int         stall_left = 0;
  int         stall_cycles = 0;

  function automatic logic [7:0] csum_of();
    logic [7:0] s = 8'h00;
    for (int i = 2; i < img.size(); i++) s = s + img[i];
    return s;
  endfunction

  task automatic build(input logic [15:0] magic, input logic [15:0] count,
                       input rec_t recs[$], input logic [7:0] delta);
    img.delete();
    exp_q.delete();
    exp_recs  = 0;
    exp_done  = 0;
    exp_error = 0;
    img.push_back(magic[15:8]);
    img.push_back(magic[7:0]);
    img.push_back(count[15:8]);
    img.push_back(count[7:0]);
    if (magic != 16'hC0F1 || count > 16'd256) begin
      exp_error = 1;
      return;
    end
    foreach (recs[i]) begin
      img.push_back(recs[i].a);
      for (int b = 3; b >= 0; b--) img.push_back(recs[i].d[8*b +: 8]);
      exp_q.push_back(recs[i]);
    end
    exp_recs = recs.size();
`ifdef CFG_CHECKSUM_EN
    begin
      logic [7:0] c;
      c = 8'h00 - csum_of();
      img.push_back(c + delta);
      exp_done  = (delta == 8'h00);
      exp_error = (delta != 8'h00);
    end
`else
    exp_done = 1;
`endif
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("done_and_error", {63'd0, done && error}, 64'd0);
      chk("rec_count_live", {48'd0, rec_count}, 64'(writes_seen));
      if (cfg_valid || done || error) chk("tready_blocked", {63'd0, s_tready}, 64'd0);
      if (cfg_valid) begin
        if (!cfg_ready) stall_cycles++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, cfg_addr, cfg_data}, 64'd0 - 64'd1);
        end else begin
          chk("write_addr", {56'd0, cfg_addr}, {56'd0, exp_q[0].a});
          chk("write_data", {32'd0, cfg_data}, {32'd0, exp_q[0].d});
          if (cfg_ready) begin
            log_q.push_back('{a: cfg_addr, d: cfg_data});
            void'(exp_q.pop_front());
            writes_seen++;
          end
        end
      end
    end
  end

  // ---------------- write-port backpressure ----------------
  always begin
    @(posedge clk);
    #1;
    if (stall_arm && cfg_valid) begin
      stall_left = 10;
      stall_arm  = 0;
    end
    if (stall_left > 0) begin
      cfg_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else if (ready_rand) begin
      cfg_ready = 1'($urandom_range(0, 1));
    end else begin
      cfg_ready = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_img(input int nbytes);
    int lim;
    bit acc;
    lim = (nbytes < img.size()) ? nbytes : img.size();
    @(posedge clk);
    #2;
    for (int i = 0; i < lim; i++) begin
      if (done || error) break;
      if (gap_en) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      end
      s_tdata  = img[i];
      s_tvalid = 1'b1;
      acc = 0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (s_tready) acc = 1;
        else if (done || error) break;
        @(posedge clk);
        #2;
        if (acc) break;
      end
      if (!acc) begin
        if (!(done || error)) chk("byte_accept_timeout", 64'(i), 64'd0 - 64'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic finish_img(input string tag);
    bit ended = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done || error) begin ended = 1; break; end
    end
    if (!ended) chk({tag, "_end_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    chk({tag, "_done"},      {63'd0, done},      {63'd0, exp_done});
    chk({tag, "_error"},     {63'd0, error},     {63'd0, exp_error});
    chk({tag, "_rec_count"}, {48'd0, rec_count}, 64'(exp_recs));
    chk({tag, "_tready"},    {63'd0, s_tready},  64'd0);
    chk({tag, "_pending"},   64'(exp_q.size()),  64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    log_q.delete();
    writes_seen  = 0;
    stall_cycles = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {16'd0, s_tready, cfg_valid, cfg_addr, cfg_data, done, error, rec_count}, 64'd0);
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  rec_t r1[$];
  rec_t rr[$];

  initial begin
    r1.push_back('{a: 8'h10, d: 32'hDEADBEEF});
    r1.push_back('{a: 8'h11, d: 32'h00000001});
    chk_en = 1;
    do_reset();

    // 1: basic two-record image
    build(16'hC0F1, 16'd2, r1, 8'h00);
    chk("model_img_len", 64'(img.size()), 64'(HDR_LEN + 10
`ifdef CFG_CHECKSUM_EN
      + 1
`endif
      ));
`ifdef CFG_CHECKSUM_EN
    chk("model_csum_byte", {56'd0, img[img.size()-1]}, 64'hA4);
`endif
    send_img(1000);
    finish_img("t1");
    chk("t1_lit_rec_count", {48'd0, rec_count}, 64'd2);
    chk("t1_lit_done", {63'd0, done}, 64'd1);
    if (log_q.size() == 2) begin
      chk("t1_lit_w0", {24'd0, log_q[0].a, log_q[0].d}, 64'h10DEADBEEF);
      chk("t1_lit_w1", {24'd0, log_q[1].a, log_q[1].d}, 64'h1100000001);
    end else chk("t1_log_size", 64'(log_q.size()), 64'd2);

    // 2: bad second magic byte
    do_reset();
    rr.delete();
    build(16'hC000, 16'd0, rr, 8'h00);
    send_img(1000);
    finish_img("t2");
    chk("t2_lit_error", {63'd0, error}, 64'd1);

    // 3: count above limit, then empty image
    do_reset();
    build(16'hC0F1, 16'h0101, rr, 8'h00);
    send_img(1000);
    finish_img("t3a");
    do_reset();
    build(16'hC0F1, 16'h0000, rr, 8'h00);
    send_img(1000);
    finish_img("t3b");
    chk("t3b_lit_done", {63'd0, done}, 64'd1);

    // 4: write port stalled for 10 cycles on record 1
    do_reset();
    build(16'hC0F1, 16'd2, r1, 8'h00);
    stall_arm = 1;
    send_img(1000);
    finish_img("t4");
    chk("t4_stall_len", 64'(stall_cycles >= 10), 64'd1);
    chk("t4_writes", 64'(log_q.size()), 64'd2);

`ifdef CFG_CHECKSUM_EN
    // 5: corrupted checksum; written records are kept
    do_reset();
    build(16'hC0F1, 16'd2, r1, 8'h01);
    send_img(1000);
    finish_img("t5");
    chk("t5_lit_error", {63'd0, error}, 64'd1);
    chk("t5_lit_recs", {48'd0, rec_count}, 64'd2);
`endif

    // 6: reset in the middle of record 2 data, then replay
    do_reset();
    build(16'hC0F1, 16'd2, r1, 8'h00);
    send_img(11);
    repeat (2) @(negedge clk);
    chk("t6_first_write", 64'(writes_seen), 64'd1);
    do_reset();
    build(16'hC0F1, 16'd2, r1, 8'h00);
    send_img(1000);
    finish_img("t6");
    chk("t6_writes_after_reset", 64'(log_q.size()), 64'd2);

    // randomized images
    ready_rand = 1;
    gap_en     = 1;
    for (int k = 0; k < 24; k++) begin
      int n;
      int kind;
      logic [15:0] mg;
      logic [15:0] cn;
      logic [7:0]  dl;
      do_reset();
      rr.delete();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        rr.push_back('{a: 8'($urandom), d: $urandom});
      kind = $urandom_range(0, 7);
      mg = 16'hC0F1;
      cn = 16'(n);
      dl = 8'h00;
      if (kind == 0) mg = 16'hC0F1 ^ (16'd1 << $urandom_range(0, 15));
      if (kind == 1) cn = 16'($urandom_range(257, 65535));
      if (kind == 2) dl = 8'($urandom_range(1, 255));
      build(mg, cn, rr, dl);
      send_img(1000);
      finish_img("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
